// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle for the cache line-refill controller: miss handshake, memory
// burst read channel and the shared bank write port.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM   = 4,
    parameter int RAM_NUM    = 4,
    parameter int BANK_AW    = 10
);
    logic                         miss_req_i;
    logic [ADDR_WIDTH-1:0]        miss_addr_i;
    logic                         miss_ready_o;
    logic                         mem_rd_req_o;
    logic [ADDR_WIDTH-1:0]        mem_rd_addr_o;
    logic                         mem_rd_gnt_i;
    logic                         mem_rd_valid_i;
    logic [DATA_WIDTH-1:0]        mem_rd_data_i;
    logic                         mem_rd_last_i;
    logic [BANK_NUM*RAM_NUM-1:0]  bank_wr_en_o;
    logic [BANK_AW-1:0]           bank_wr_addr_o;
    logic [DATA_WIDTH-1:0]        bank_wr_data_o;
    logic                         refill_done_o;
    logic                         refill_err_o;

    // Controller side
    modport slave (
        input  miss_req_i, miss_addr_i, mem_rd_gnt_i, mem_rd_valid_i,
               mem_rd_data_i, mem_rd_last_i,
        output miss_ready_o, mem_rd_req_o, mem_rd_addr_o, bank_wr_en_o,
               bank_wr_addr_o, bank_wr_data_o, refill_done_o, refill_err_o
    );

    // Cache FSM / memory / bank side
    modport master (
        output miss_req_i, miss_addr_i, mem_rd_gnt_i, mem_rd_valid_i,
               mem_rd_data_i, mem_rd_last_i,
        input  miss_ready_o, mem_rd_req_o, mem_rd_addr_o, bank_wr_en_o,
               bank_wr_addr_o, bank_wr_data_o, refill_done_o, refill_err_o
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line-refill controller: one BANK_NUM-beat burst read per miss, one
// registered bank write per beat. Option macro: REFILL_CRITICAL_WORD_FIRST_EN.
//
// state | meaning
// IDLE  | ready for a miss, address capture on miss_req_i
// REQ   | burst request held until grant
// RECV  | collecting beats, one bank write per beat
// DONE  | final bank write visible, refill_done_o pulse
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_NUM   = 4,
    parameter int RAM_NUM    = 4,
    parameter int BANK_AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_refill_ctrl_if.slave   bus
);
    localparam int OFF_LSB  = $clog2(DATA_WIDTH/8);
    localparam int PTR_W    = $clog2(BANK_NUM);
    localparam int LINE_LSB = OFF_LSB + PTR_W;
    localparam int IDX_W    = BANK_AW - OFF_LSB;
    localparam int EN_W     = BANK_NUM * RAM_NUM;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [PTR_W-1:0]      r_beat_ptr;
    logic [PTR_W-1:0]      r_rcv_cnt;
    logic [EN_W-1:0]       r_wr_en;
    logic [BANK_AW-1:0]    r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_err;

    logic                  w_capture;
    logic                  w_beat;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_req;
    logic                  w_done;
    logic [PTR_W-1:0]      w_start_ptr;
    logic [EN_W-1:0]       w_wr_en;
    logic [ADDR_WIDTH-1:0] w_burst_addr;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    // Wrap burst: memory returns the missed word first
    assign w_start_ptr  = bus.miss_addr_i[LINE_LSB-1:OFF_LSB];
    assign w_burst_addr = {r_addr[ADDR_WIDTH-1:OFF_LSB], {OFF_LSB{1'b0}}};
`else
    assign w_start_ptr  = '0;
    assign w_burst_addr = {r_addr[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_beat    = 1'b0;
        w_err     = 1'b0;
        w_ready   = 1'b0;
        w_req     = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.miss_req_i) begin
                    w_capture = 1'b1;
                    w_next    = S_REQ;
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (bus.mem_rd_gnt_i) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                if (bus.mem_rd_valid_i) begin
                    w_beat = 1'b1;
                    if (r_rcv_cnt == PTR_W'(BANK_NUM-1)) begin
                        // A full line is always committed; a missing last flag is only flagged
                        w_err  = !bus.mem_rd_last_i;
                        w_next = S_DONE;
                    end else if (bus.mem_rd_last_i) begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (r_beat_ptr == PTR_W'(b)) begin
                w_wr_en[b*RAM_NUM +: RAM_NUM] = {RAM_NUM{1'b1}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_beat_ptr <= '0;
            r_rcv_cnt  <= '0;
            r_wr_en    <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr     <= bus.miss_addr_i;
                r_beat_ptr <= w_start_ptr;
                r_rcv_cnt  <= '0;
            end
            if (w_beat) begin
                r_beat_ptr <= r_beat_ptr + PTR_W'(1);
                r_rcv_cnt  <= r_rcv_cnt + PTR_W'(1);
                r_wr_addr  <= {r_addr[LINE_LSB +: IDX_W], {OFF_LSB{1'b0}}};
                r_wr_data  <= bus.mem_rd_data_i;
            end
            r_wr_en <= w_beat ? w_wr_en : '0;
            r_err   <= w_err;
        end
    end

    assign bus.miss_ready_o   = w_ready;
    assign bus.mem_rd_req_o   = w_req;
    assign bus.mem_rd_addr_o  = w_req ? w_burst_addr : '0;
    assign bus.bank_wr_en_o   = r_wr_en;
    assign bus.bank_wr_addr_o = r_wr_addr;
    assign bus.bank_wr_data_o = r_wr_data;
    assign bus.refill_done_o  = w_done;
    assign bus.refill_err_o   = r_err;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scoreboard bench for cache_refill_ctrl: the driver predicts bank
// writes and done/err pulses per refill, a negedge monitor checks them.
module tb_cache_refill_ctrl;
    localparam int AW = 32, DW = 32, BN = 4, RN = 4, BAW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN),
                           .RAM_NUM(RN), .BANK_AW(BAW)) bus ();

    cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN),
                        .RAM_NUM(RN), .BANK_AW(BAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] en;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic done;
        logic err;
    } ev_t;

    wr_t wq[$];
    ev_t eq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every visible bank write and done/err pulse must match the queue head
    always @(negedge clk) begin
        wr_t w;
        ev_t e;
        if (!rst_n) begin
            if (bus.bank_wr_en_o != '0 || bus.refill_done_o || bus.refill_err_o)
                check("reset_quiet", {bus.bank_wr_en_o, bus.refill_done_o, bus.refill_err_o}, 0);
        end else begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                check("write_missing", 0, w.en);
            end
            if (bus.bank_wr_en_o != '0) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", bus.bank_wr_en_o, 0);
                end else begin
                    w = wq.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_en", bus.bank_wr_en_o, w.en);
                    check("wr_addr", bus.bank_wr_addr_o, w.addr);
                    check("wr_data", bus.bank_wr_data_o, w.data);
                end
            end
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                e = eq.pop_front();
                check("event_missing", 0, {e.done, e.err});
            end
            if (bus.refill_done_o || bus.refill_err_o) begin
                if (eq.size() == 0) begin
                    check("unexpected_event", {bus.refill_done_o, bus.refill_err_o}, 0);
                end else begin
                    e = eq.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_done_err", {bus.refill_done_o, bus.refill_err_o}, {e.done, e.err});
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.miss_ready_o, 1);
        check({tag, "_req"}, bus.mem_rd_req_o, 0);
        check({tag, "_rdaddr"}, bus.mem_rd_addr_o, 0);
        check({tag, "_wren"}, bus.bank_wr_en_o, 0);
        check({tag, "_wraddr"}, bus.bank_wr_addr_o, 0);
        check({tag, "_wrdata"}, bus.bank_wr_data_o, 0);
        check({tag, "_done_err"}, {bus.refill_done_o, bus.refill_err_o}, 0);
    endtask

    // last_at: beat number carrying mem_rd_last_i (0 = never); rst_at: reset after that beat
    task automatic do_refill(input logic [31:0] addr, input int gdly, input int gapmax,
                             input int last_at, input int rst_at);
        int          start;
        int          gaps;
        int          bank;
        logic [31:0] raddr;
        logic [9:0]  waddr;
        logic [15:0] en;
        logic [31:0] data;
        logic        last;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        start = int'(addr[3:2]);
        raddr = {addr[31:2], 2'b00};
`else
        start = 0;
        raddr = {addr[31:4], 4'b0000};
`endif
        waddr = {addr[11:4], 2'b00};

        check("idle_ready", bus.miss_ready_o, 1);
        bus.miss_req_i  = 1'b1;
        bus.miss_addr_i = addr;
        step();
        bus.miss_req_i  = 1'b0;
        bus.miss_addr_i = $urandom;
        check("req_ready_low", bus.miss_ready_o, 0);
        check("req_asserted", bus.mem_rd_req_o, 1);
        check("req_addr", bus.mem_rd_addr_o, raddr);
        for (int i = 0; i < gdly; i++) begin
            bus.mem_rd_gnt_i   = 1'b0;
            bus.mem_rd_valid_i = 1'($urandom_range(1, 0));
            bus.mem_rd_data_i  = $urandom;
            step();
            check("req_held", bus.mem_rd_req_o, 1);
            check("req_addr_stable", bus.mem_rd_addr_o, raddr);
        end
        bus.mem_rd_gnt_i   = 1'b1;
        bus.mem_rd_valid_i = 1'($urandom_range(1, 0));
        step();
        bus.mem_rd_gnt_i   = 1'b0;
        bus.mem_rd_valid_i = 1'b0;

        for (int n = 1; n <= BN; n++) begin
            gaps = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.mem_rd_valid_i = 1'b0;
                bus.miss_req_i     = 1'($urandom_range(1, 0));
                bus.miss_addr_i    = $urandom;
                bus.mem_rd_data_i  = $urandom;
                step();
                check("gap_ready_low", bus.miss_ready_o, 0);
            end
            bus.miss_req_i = 1'b0;
            data = $urandom;
            last = (n == last_at);
            bank = (start + n - 1) % BN;
            en   = '0;
            en[bank*RN +: RN] = '1;
            bus.mem_rd_valid_i = 1'b1;
            bus.mem_rd_data_i  = data;
            bus.mem_rd_last_i  = last;
            wq.push_back('{cyc + 1, en, waddr, data});
            if (n == BN)
                eq.push_back('{cyc + 1, 1'b1, !last});
            else if (last)
                eq.push_back('{cyc + 1, 1'b0, 1'b1});
            step();
            bus.mem_rd_valid_i = 1'b0;
            bus.mem_rd_last_i  = 1'b0;
            if (rst_at == n) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("midrst");
                for (int k = 0; k < 3; k++) begin
                    bus.mem_rd_valid_i = 1'b1;
                    bus.mem_rd_data_i  = $urandom;
                    step();
                end
                @(negedge clk);
                #2 rst_n = 1'b1;
                step();
                bus.mem_rd_valid_i = 1'b0;
                step();
                check("after_rst_ready", bus.miss_ready_o, 1);
                return;
            end
            if (last && n < BN) begin
                check("early_last_ready", bus.miss_ready_o, 1);
                return;
            end
        end
        check("done_ready_low", bus.miss_ready_o, 0);
        step();
        check("post_done_ready", bus.miss_ready_o, 1);
    endtask

    initial begin
        int la;
        bus.miss_req_i     = 1'b0;
        bus.miss_addr_i    = '0;
        bus.mem_rd_gnt_i   = 1'b0;
        bus.mem_rd_valid_i = 1'b0;
        bus.mem_rd_data_i  = '0;
        bus.mem_rd_last_i  = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_refill(32'h0000_1238, 2, 0, 4, 0);   // basic
        do_refill(32'h0000_1238, 0, 0, 4, 0);   // minimum latency
        do_refill($urandom, 1, 3, 4, 0);        // gapped beats
        do_refill($urandom, 0, 1, 2, 0);        // early last
        do_refill($urandom, 1, 1, 0, 0);        // no last flag on final beat
        do_refill($urandom, 0, 0, 4, 1);        // reset after beat 1

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(9, 0))
                0, 1:    la = $urandom_range(3, 1);
                2:       la = 0;
                default: la = 4;
            endcase
            do_refill($urandom, $urandom_range(3, 0), $urandom_range(2, 0), la, 0);
            // stray beat while idle must be ignored
            bus.mem_rd_valid_i = 1'($urandom_range(1, 0));
            bus.mem_rd_data_i  = $urandom;
            step();
            bus.mem_rd_valid_i = 1'b0;
        end

        repeat (4) step();
        check("wq_drained", wq.size(), 0);
        check("eq_drained", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
